// File: rtl/acc_resp_pkg.sv
// acc_resp_pkg: shared types for the accelerator dispatch responder.
package acc_resp_pkg;
  localparam int unsigned XLEN = 64;
  localparam int unsigned TRANS_ID_W = 3;

  typedef struct packed {
    logic [31:0]           insn;
    logic [XLEN-1:0]       rs1;
    logic [XLEN-1:0]       rs2;
    logic [TRANS_ID_W-1:0] trans_id;
  } acc_req_t;

  typedef struct packed {
    logic [XLEN-1:0]       result;
    logic [TRANS_ID_W-1:0] trans_id;
    logic                  error;
  } acc_resp_t;

  typedef enum logic {RUN, DRAIN} state_t;
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: ring-buffer FIFO with optional fall-through and synchronous active-low reset.
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic [DATA_WIDTH-1:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  dtype          r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [AW:0]   r_cnt;
  logic          w_ft;
  logic          w_wr;
  logic          w_rd;
  assign w_ft    = FALL_THROUGH && (r_cnt == '0) && push_i;
  assign full_o  = r_cnt == (AW+1)'(DEPTH);
  assign empty_o = (r_cnt == '0) && !w_ft;
  assign data_o  = w_ft ? data_i : r_mem[r_rd];
  assign w_rd    = pop_i && (r_cnt != '0);
  // A fall-through word popped in the same cycle never touches storage.
  assign w_wr    = push_i && (!full_o || w_rd) && !(w_ft && pop_i);
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr] <= data_i;
        r_wr        <= r_wr + 1'b1;
      end
      if (w_rd) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/acc_dispatch_responder.sv
// acc_dispatch_responder: accelerator end of the CVA6 dispatch interface; buffers, issues in order, answers in order.
// Define ACC_RESP_PERF_CNT_EN to add the perf_issued_o / perf_stall_o counters.
module acc_dispatch_responder
  import acc_resp_pkg::*;
#(
  parameter int unsigned REQ_DEPTH       = 4,
  parameter int unsigned MAX_OUTSTANDING = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [31:0]           req_insn_i,
  input  logic [XLEN-1:0]       req_rs1_i,
  input  logic [XLEN-1:0]       req_rs2_i,
  input  logic [TRANS_ID_W-1:0] req_trans_id_i,
  output logic                  issue_valid_o,
  input  logic                  issue_ready_i,
  output logic [31:0]           issue_insn_o,
  output logic [XLEN-1:0]       issue_rs1_o,
  output logic [XLEN-1:0]       issue_rs2_o,
  input  logic                  result_valid_i,
  output logic                  result_ready_o,
  input  logic [XLEN-1:0]       result_data_i,
  input  logic                  result_error_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [XLEN-1:0]       resp_result_o,
  output logic [TRANS_ID_W-1:0] resp_trans_id_o,
  output logic                  resp_error_o,
`ifdef ACC_RESP_PERF_CNT_EN
  output logic [31:0]           perf_issued_o,
  output logic [31:0]           perf_stall_o,
`endif
  output logic                  busy_o
);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  acc_req_t              w_req_in;
  acc_req_t              w_req_head;
  acc_resp_t             r_resp;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [OW-1:0]         r_outstanding;
  logic [OW-1:0]         w_out_nxt;
  logic [TRANS_ID_W-1:0] w_id_head;
  logic                  r_resp_valid;
  logic                  w_req_full;
  logic                  w_req_empty;
  logic                  w_id_full;
  logic                  w_id_empty;
  logic                  w_run;
  logic                  w_req_push;
  logic                  w_issue_fire;
  logic                  w_result_fire;
  logic                  w_id_pop;

  assign w_req_in = '{insn: req_insn_i, rs1: req_rs1_i, rs2: req_rs2_i, trans_id: req_trans_id_i};
  // A flush cycle already behaves like DRAIN so nothing new is accepted or issued.
  assign w_run          = (r_state == RUN) && !flush_i;
  assign req_ready_o    = rst_ni && w_run && !w_req_full;
  assign w_req_push     = req_valid_i && req_ready_o;
  assign issue_valid_o  = rst_ni && w_run && !w_req_empty && !w_id_full && (r_outstanding < MAX_OUT);
  assign w_issue_fire   = issue_valid_o && issue_ready_i;
  assign issue_insn_o   = w_req_head.insn;
  assign issue_rs1_o    = w_req_head.rs1;
  assign issue_rs2_o    = w_req_head.rs2;
  assign result_ready_o = rst_ni && (!w_run || !r_resp_valid || resp_ready_i);
  assign w_result_fire  = result_valid_i && result_ready_o;
  assign w_id_pop       = w_result_fire && !w_id_empty;
  assign w_out_nxt      = r_outstanding + OW'(w_issue_fire) - OW'(w_id_pop);
  assign w_state_nxt    = ((r_state == DRAIN || flush_i) && w_out_nxt != '0) ? DRAIN : RUN;

  assign resp_valid_o    = r_resp_valid;
  assign resp_result_o   = r_resp.result;
  assign resp_trans_id_o = r_resp.trans_id;
  assign resp_error_o    = r_resp.error;
  assign busy_o          = !w_req_empty || r_outstanding != '0 || r_resp_valid || r_state == DRAIN;

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   ($bits(acc_req_t)),
    .DEPTH        (REQ_DEPTH),
    .dtype        (acc_req_t)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .full_o  (w_req_full),
    .empty_o (w_req_empty),
    .data_i  (w_req_in),
    .push_i  (w_req_push),
    .data_o  (w_req_head),
    .pop_i   (w_issue_fire)
  );

  // Issued IDs survive a flush: the backend still answers them and they must be drained.
  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (TRANS_ID_W),
    .DEPTH        (MAX_OUTSTANDING)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (1'b0),
    .full_o  (w_id_full),
    .empty_o (w_id_empty),
    .data_i  (w_req_head.trans_id),
    .push_i  (w_issue_fire),
    .data_o  (w_id_head),
    .pop_i   (w_id_pop)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state       <= RUN;
      r_outstanding <= '0;
      r_resp_valid  <= 1'b0;
      r_resp        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= w_out_nxt;
      if (!w_run) begin
        r_resp_valid <= 1'b0;
        r_resp       <= '0;
      end else if (w_result_fire) begin
        r_resp_valid <= 1'b1;
        r_resp       <= '{result: result_data_i, trans_id: w_id_head, error: result_error_i};
      end else if (resp_ready_i) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  a_result_has_id: assert property (@(posedge clk_i) disable iff (!rst_ni) result_valid_i |-> !w_id_empty);

`ifdef ACC_RESP_PERF_CNT_EN
  logic [31:0] r_perf_issued;
  logic [31:0] r_perf_stall;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_perf_issued <= '0;
      r_perf_stall  <= '0;
    end else begin
      r_perf_issued <= r_perf_issued + 32'(w_issue_fire);
      r_perf_stall  <= r_perf_stall + 32'(issue_valid_o && !issue_ready_i);
    end
  end
  assign perf_issued_o = r_perf_issued;
  assign perf_stall_o  = r_perf_stall;
`endif
endmodule

// File: doc/acc_dispatch_responder.md
Name: acc_dispatch_responder

Overview:
- Accelerator-side end of the CVA6 accelerator dispatch interface, used when the vector extension is enabled (RVV=1, XLEN=64).
- Accepts instructions offloaded by the core's dispatcher and buffers them. Issues them in order to the vector backend.
- Pairs backend results with the originating scoreboard transaction ID and returns responses to the core in program order. Handles core-initiated flushes.

Parameters:
- XLEN, 64, width of rs1/rs2 operands and result.
- TRANS_ID_W, 3, scoreboard transaction ID width (8 scoreboard entries).
- REQ_DEPTH, 4, request FIFO depth (power of two, >=2).
- MAX_OUTSTANDING, 8, maximum issued-but-unanswered instructions (power of two).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- flush_i  in  1  core flush; drops all speculative state.
- req_valid_i  in  1  offload request valid.
- req_ready_o  out  1  request accepted when valid&ready.
- req_insn_i  in  32  instruction word.
- req_rs1_i  in  XLEN  rs1 value.
- req_rs2_i  in  XLEN  rs2 value.
- req_trans_id_i  in  TRANS_ID_W  scoreboard ID.
- issue_valid_o  out  1  instruction to backend valid.
- issue_ready_i  in  1  backend accepts.
- issue_insn_o  out  32  issued instruction.
- issue_rs1_o  out  XLEN  issued rs1.
- issue_rs2_o  out  XLEN  issued rs2.
- result_valid_i  in  1  backend result valid (in issue order).
- result_ready_o  out  1  result consumed.
- result_data_i  in  XLEN  result value.
- result_error_i  in  1  backend exception.
- resp_valid_o  out  1  response to core valid.
- resp_ready_i  in  1  core accepts response.
- resp_result_o  out  XLEN  result.
- resp_trans_id_o  out  TRANS_ID_W  matching ID.
- resp_error_o  out  1  exception flag.
- busy_o  out  1  any instruction buffered, outstanding, or responding.

Behaviour:
- Reset (rst_ni=0 sampled at clk edge): FIFOs empty, outstanding counter 0, FSM=RUN. All valid/ready outputs 0, data outputs 0, busy_o=0.
- Request FIFO (REQ_DEPTH) stores {insn, rs1, rs2, trans_id}.
  - req_ready_o = !full && state==RUN.
  - Push and pop in the same cycle while full is allowed only if pop occurs. req_ready_o is not combinationally dependent on issue_ready_i.
- Issue: issue_valid_o = !req_empty && outstanding < MAX_OUTSTANDING && state==RUN; data from FIFO head.
  - On issue handshake, pop the request FIFO and push trans_id into the ID FIFO (depth MAX_OUTSTANDING).
  - Outstanding counter +1, saturating never needed (guarded).
- Minimum latency request to issue: 1 cycle (registered FIFO, no fall-through).
- Result: result_ready_o = !resp_reg_full || resp_ready_i (single-entry response register with pass-through refill).
  - On result handshake, pop the ID FIFO and load the response register with {result, popped ID, error}. Outstanding counter -1.
  - Result to resp_valid_o latency: 1 cycle.
- Simultaneous issue and result in the same cycle: counter unchanged, both FIFOs update.
- Response held stable while resp_valid_o && !resp_ready_i.
- FSM states: RUN, DRAIN.
  - RUN -> DRAIN on flush_i: request FIFO cleared, response register cleared, in-flight issue cancelled.
  - DRAIN: result_ready_o=1, results popped from the ID FIFO and discarded (no response). req_ready_o=0, issue_valid_o=0.
  - DRAIN -> RUN when outstanding==0 (including the cycle it reaches 0). flush_i with outstanding==0 stays in RUN after clearing.
  - flush_i while in DRAIN: remain in DRAIN.
- A result arriving with the ID FIFO empty is an assertion failure (result_ready_o still 1 to avoid deadlock).
- Pointers wrap modulo depth; counters have clog2(depth)+1 bits to disambiguate full/empty.
- busy_o = !req_empty || outstanding!=0 || resp_valid_o || state==DRAIN.

Optional Feature:
- Macro ACC_RESP_PERF_CNT_EN.
- Defined: adds outputs perf_issued_o[31:0] (issue handshakes) and perf_stall_o[31:0] (cycles issue_valid_o && !issue_ready_i). Both wrap at 2^32, reset to 0, and are unaffected by flush.
- Undefined: ports absent, no counter logic.

Decomposition:
- Package acc_resp_pkg: acc_req_t {insn, rs1, rs2, trans_id}, acc_resp_t {result, trans_id, error}, parameterised via XLEN/TRANS_ID_W localparams; state enum {RUN, DRAIN}.
- Request FIFO and ID FIFO instantiate the common-cells fifo_v3 (FALL_THROUGH=0); no other sub-module.

Test Plan:
- Single request insn=0x02057057, id=3, rs1=0x10, backend returns 0xAB after 2 cycles -> resp_valid_o with result 0xAB, id 3, error 0, issue one cycle after accept.
- 6 back-to-back requests ids 0..5, issue_ready_i=0 -> req_ready_o drops after 4 accepted. Releasing issue drains in order; responses ids 0..5 in order.
- 8 issued, no results -> issue_valid_o=0 with FIFO non-empty. One result -> outstanding 7, issue resumes next cycle.
- resp_ready_i=0 for 5 cycles with results pending -> response stable, result_ready_o=0, no data loss.
- flush_i with 3 outstanding, 2 buffered -> FIFO cleared, DRAIN. 3 results discarded, no resp_valid_o, back in RUN, busy_o=0.
- result_error_i=1 on id 6 -> resp_error_o=1, id 6; subsequent responses unaffected.
